vga_sync_gen: RTL and testbench

VGA 640x480@60 timing generator and pixel output stage; the driving end of the pixel-coordinate interface consumed by the UI renderer. Produces the `x`/`y` scan coordinates the renderer evaluates. Accepts the renderer's registered RGB back, re-aligns hsync/vsync/blanking to the renderer's pipeline latency, and drives the 4-bit-per-channel VGA pins.

---
 rtl/color_pkg.sv | 26 ++
 rtl/vga_pkg.sv | 28 ++
 rtl/sync_delay.sv | 29 ++
 rtl/vga_sync_gen.sv | 170 +++++++++++++++++
 tb/tb_vga_sync_gen.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared 4-bit-per-channel colour type and colour-bar palette
package color_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Classic eight-bar order, brightest on the left
    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = rgb_t'(12'hFFF);
            3'd1:    c = rgb_t'(12'hFF0);
            3'd2:    c = rgb_t'(12'h0FF);
            3'd3:    c = rgb_t'(12'h0F0);
            3'd4:    c = rgb_t'(12'hF0F);
            3'd5:    c = rgb_t'(12'hF00);
            3'd6:    c = rgb_t'(12'h00F);
            default: c = rgb_t'(12'h000);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing defaults and derived constants
package vga_pkg;

    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_RENDER_LAT = 1;

    function automatic int timing_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int timing_sync_start(input int vis, input int fp);
        return vis + fp;
    endfunction

    localparam int H_TOTAL      = timing_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL      = timing_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int H_SYNC_START = timing_sync_start(DEF_H_VISIBLE, DEF_H_FP);
    localparam int V_SYNC_START = timing_sync_start(DEF_V_VISIBLE, DEF_V_FP);

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - fixed-depth shift register with per-bit reset value
module sync_delay #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    // Shift one stage per clock; reset loads every stage with the idle pattern
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stage <= {DEPTH{RESET_VAL}};
        end else begin
            r_stage[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator and pixel output stage (optional colour bars: VGA_TEST_PATTERN_EN)
module vga_sync_gen
    import vga_pkg::*;
    import color_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int RENDER_LAT = DEF_RENDER_LAT
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pixel_tick,
    output logic       frame_start,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic       test_pattern,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [9:0] V_LAST   = 10'(timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [9:0] HS_FIRST = 10'(timing_sync_start(H_VISIBLE, H_FP));
    localparam logic [9:0] HS_LAST  = 10'(timing_sync_start(H_VISIBLE, H_FP) + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(timing_sync_start(V_VISIBLE, V_FP));
    localparam logic [9:0] VS_LAST  = 10'(timing_sync_start(V_VISIBLE, V_FP) + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;
    logic             r_frame_start;
    logic             r_hsync;
    logic             r_vsync;
    rgb_t             r_rgb;

    logic w_tick, w_h_last, w_v_last;
    logic w_hs_raw, w_vs_raw, w_de_raw;
    logic w_hs_d, w_vs_d, w_de_d;
    rgb_t w_color;
    logic w_unused;

    assign w_tick   = (r_div_cnt == DIV_LAST);
    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    // Pixel divider and scan counters; frame_start rises together with the (0,0) coordinates
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && w_h_last && w_v_last;
            if (w_tick) begin
                r_div_cnt <= '0;
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    assign w_hs_raw = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
    assign w_vs_raw = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));
    assign w_de_raw = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);

`ifdef VGA_TEST_PATTERN_EN
    localparam int               DLY_W   = 16;
    localparam logic [DLY_W-1:0] DLY_RST = {3'b110, 13'd0};
    localparam logic [9:0]       BAR_W   = 10'(H_VISIBLE / 8);

    logic [2:0]       w_bar_idx;
    logic [DLY_W-1:0] w_dly_in, w_dly_out;
    logic             w_sel_d;
    rgb_t             w_pat_d;

    // Bar index from the horizontal position; off-screen columns fold onto the last bar
    always_comb begin
        w_bar_idx = 3'd7;
        if (r_h_cnt < H_VIS) begin
            w_bar_idx = 3'(r_h_cnt / BAR_W);
        end
    end

    assign w_dly_in = {w_hs_raw, w_vs_raw, w_de_raw, test_pattern, bar_color(w_bar_idx)};
    assign w_sel_d  = w_dly_out[12];
    assign w_pat_d  = rgb_t'(w_dly_out[11:0]);
    assign w_unused = ^{r_in[3:0], g_in[3:0], b_in[3:0]};
`else
    localparam int               DLY_W   = 3;
    localparam logic [DLY_W-1:0] DLY_RST = 3'b110;

    logic [DLY_W-1:0] w_dly_in, w_dly_out;

    assign w_dly_in = {w_hs_raw, w_vs_raw, w_de_raw};
    assign w_unused = ^{r_in[3:0], g_in[3:0], b_in[3:0], test_pattern};
`endif

    sync_delay #(
        .WIDTH     (DLY_W),
        .DEPTH     (RENDER_LAT),
        .RESET_VAL (DLY_RST)
    ) u_sync_delay (
        .i_clk   (clk),
        .i_reset (reset),
        .i_din   (w_dly_in),
        .o_dout  (w_dly_out)
    );

    assign w_hs_d = w_dly_out[DLY_W-1];
    assign w_vs_d = w_dly_out[DLY_W-2];
    assign w_de_d = w_dly_out[DLY_W-3];

    // Colour source: renderer's upper nibbles, or the bar generator when selected
    always_comb begin
        w_color = rgb_t'({r_in[7:4], g_in[7:4], b_in[7:4]});
`ifdef VGA_TEST_PATTERN_EN
        if (w_sel_d) begin
            w_color = w_pat_d;
        end
`endif
    end

    // Pin register: sync and blanked colour leave on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_hs_d;
            r_vsync <= w_vs_d;
            r_rgb   <= w_de_d ? w_color : '0;
        end
    end

    assign x           = r_h_cnt;
    assign y           = r_v_cnt;
    assign pixel_tick  = w_tick;
    assign frame_start = r_frame_start;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign vga_r       = r_rgb.r;
    assign vga_g       = r_rgb.g;
    assign vga_b       = r_rgb.b;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed-vector bench for vga_sync_gen (default and reduced timing)
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] r_in = 8'hA5, g_in = 8'hA5, b_in = 8'hA5;
    logic       test_pattern = 1'b0;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_tick, d_fs, d_hs, d_vs, s_tick, s_fs, s_hs, s_vs;
    logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;

    always #5 clk = ~clk;

    vga_sync_gen u_dflt (
        .clk(clk), .reset(reset), .x(d_x), .y(d_y), .pixel_tick(d_tick), .frame_start(d_fs),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .test_pattern(test_pattern),
        .vga_hsync(d_hs), .vga_vsync(d_vs), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
    );

    // 24x11 total frame, sync at h=18..20 / v=7..8, two-stage renderer latency
    vga_sync_gen #(
        .CLK_DIV(4), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .RENDER_LAT(2)
    ) u_small (
        .clk(clk), .reset(reset), .x(s_x), .y(s_y), .pixel_tick(s_tick), .frame_start(s_fs),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .test_pattern(test_pattern),
        .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
    );

    typedef struct {
        int         t;
        logic [7:0] ri, gi, bi;
        logic [9:0] ex, ey;
        logic       etick, ehs, evs;
        logic [11:0] ergb;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int n_total = 0;
    int n_pass  = 0;
    int cur_t   = 0;
    int hs_low  = 0;
    int hs_first = -1;
    bit hs_count_en = 1'b0;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cur_t++;
        if (hs_count_en && cur_t <= 3200 && d_hs == 1'b0) begin
            if (hs_first < 0) hs_first = cur_t;
            hs_low++;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        cur_t = 0;
    endtask

    int fs_cnt, fs_first, vs_low, vs_first;
    logic [11:0] exp_pat [4];
    int          pat_t   [4];

    initial begin
        //          t     r      g      b      x     y   tick hs  vs  rgb
        vecs[0]  = '{1,    8'hA5, 8'hA5, 8'hA5, 0,    0,  0,   1,  1,  12'h000};
        vecs[1]  = '{2,    8'hA5, 8'hA5, 8'hA5, 0,    0,  0,   1,  1,  12'hAAA};
        vecs[2]  = '{3,    8'h3C, 8'h7E, 8'hF1, 0,    0,  1,   1,  1,  12'h37F};
        vecs[3]  = '{4,    8'h12, 8'h34, 8'h56, 1,    0,  0,   1,  1,  12'h135};
        vecs[4]  = '{2561, 8'hA5, 8'hA5, 8'hA5, 640,  0,  0,   1,  1,  12'hAAA};
        vecs[5]  = '{2562, 8'hA5, 8'hA5, 8'hA5, 640,  0,  0,   1,  1,  12'h000};
        vecs[6]  = '{2625, 8'hA5, 8'hA5, 8'hA5, 656,  0,  0,   1,  1,  12'h000};
        vecs[7]  = '{2626, 8'hA5, 8'hA5, 8'hA5, 656,  0,  0,   0,  1,  12'h000};
        vecs[8]  = '{3009, 8'hA5, 8'hA5, 8'hA5, 752,  0,  0,   0,  1,  12'h000};
        vecs[9]  = '{3010, 8'hA5, 8'hA5, 8'hA5, 752,  0,  0,   1,  1,  12'h000};
        vecs[10] = '{3199, 8'hA5, 8'hA5, 8'hA5, 799,  0,  1,   1,  1,  12'h000};
        vecs[11] = '{3200, 8'hA5, 8'hA5, 8'hA5, 0,    1,  0,   1,  1,  12'h000};
        vecs[12] = '{3202, 8'hFF, 8'h00, 8'h80, 0,    1,  0,   1,  1,  12'hF08};

        // Reset state after a 5-cycle reset
        do_reset(5);
        check("rst_x", 0, 32'(d_x), 0);
        check("rst_y", 0, 32'(d_y), 0);
        check("rst_tick", 0, 32'(d_tick), 0);
        check("rst_fs", 0, 32'(d_fs), 0);
        check("rst_hs", 0, 32'(d_hs), 1);
        check("rst_vs", 0, 32'(d_vs), 1);
        check("rst_rgb", 0, 32'({d_r, d_g, d_b}), 0);

        // Default-timing vectors over the first line and a bit
        hs_count_en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            while (cur_t < vecs[i].t - 1) step();
            r_in = vecs[i].ri;
            g_in = vecs[i].gi;
            b_in = vecs[i].bi;
            step();
            check("vec_x", i, 32'(d_x), 32'(vecs[i].ex));
            check("vec_y", i, 32'(d_y), 32'(vecs[i].ey));
            check("vec_tick", i, 32'(d_tick), 32'(vecs[i].etick));
            check("vec_hs", i, 32'(d_hs), 32'(vecs[i].ehs));
            check("vec_vs", i, 32'(d_vs), 32'(vecs[i].evs));
            check("vec_rgb", i, 32'({d_r, d_g, d_b}), 32'(vecs[i].ergb));
        end
        hs_count_en = 1'b0;
        check("hs_low_len", 0, 32'(hs_low), 384);
        check("hs_first", 0, 32'(hs_first), 2626);

        // Reduced frame: one frame_start, vsync width and position
        r_in = 8'hA5; g_in = 8'hA5; b_in = 8'hA5;
        do_reset(2);
        fs_cnt = 0; fs_first = -1; vs_low = 0; vs_first = -1;
        while (cur_t < 1386) begin
            step();
            if (s_fs) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = cur_t;
            end
            if (cur_t <= 1056 && !s_vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = cur_t;
            end
        end
        check("frm_fs_cnt", 0, 32'(fs_cnt), 1);
        check("frm_fs_t", 0, 32'(fs_first), 1056);
        check("frm_vs_len", 0, 32'(vs_low), 192);
        check("frm_vs_first", 0, 32'(vs_first), 675);
        check("mid_x", 0, 32'(s_x), 10);
        check("mid_y", 0, 32'(s_y), 3);
        check("mid_rgb", 0, 32'({s_r, s_g, s_b}), 12'hAAA);

        // Mid-frame reset at div phase 2 inside the visible area
        do_reset(1);
        check("mrst_x", 0, 32'(s_x), 0);
        check("mrst_y", 0, 32'(s_y), 0);
        check("mrst_tick", 0, 32'(s_tick), 0);
        check("mrst_fs", 0, 32'(s_fs), 0);
        check("mrst_hs", 0, 32'(s_hs), 1);
        check("mrst_vs", 0, 32'(s_vs), 1);
        check("mrst_rgb", 0, 32'({s_r, s_g, s_b}), 0);
        step();
        check("mrst_rgb", 1, 32'({s_r, s_g, s_b}), 0);
        check("mrst_tick", 1, 32'(s_tick), 0);
        step();
        check("mrst_rgb", 2, 32'({s_r, s_g, s_b}), 0);
        step();
        check("mrst_rgb", 3, 32'({s_r, s_g, s_b}), 12'hAAA);
        check("mrst_tick", 3, 32'(s_tick), 1);
        fs_cnt = 0; fs_first = -1;
        while (cur_t < 1060) begin
            step();
            if (s_fs) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = cur_t;
            end
        end
        check("mrst_fs_cnt", 0, 32'(fs_cnt), 1);
        check("mrst_fs_t", 0, 32'(fs_first), 1056);

        // Colour bars (or pass-through when the generator is not built)
        pat_t[0] = 2;    pat_t[1] = 322;  pat_t[2] = 2238; pat_t[3] = 2242;
`ifdef VGA_TEST_PATTERN_EN
        exp_pat[0] = 12'hFFF; exp_pat[1] = 12'hFF0; exp_pat[2] = 12'h00F; exp_pat[3] = 12'h000;
`else
        exp_pat[0] = 12'hAAA; exp_pat[1] = 12'hAAA; exp_pat[2] = 12'hAAA; exp_pat[3] = 12'hAAA;
`endif
        test_pattern = 1'b1;
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            while (cur_t < pat_t[i]) step();
            check("pat_rgb", i, 32'({d_r, d_g, d_b}), 32'(exp_pat[i]));
        end
        test_pattern = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
